chunked_signed_negate: RTL and testbench

//   Multi-cycle signed 2's complement unit: pass, negate (-x) or absolute value (|x|).
//   The invert-plus-one carry chain is split into CHUNK-bit slices, one slice per cycle,

---
 rtl/chunked_signed_negate_if.sv | 25 ++
 rtl/chunked_signed_negate.sv | 116 +++++++++++
 tb/tb_chunked_signed_negate.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/chunked_signed_negate_if.sv
// Handshake bundle for chunked_signed_negate: operand/mode in, result/overflow out.
// The master side presents operands and consumes results; the slave side is the unit.
interface chunked_signed_negate_if #(
  parameter int BITS = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic [1:0]      mode;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic            overflow;
  logic            busy;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, overflow, busy
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, overflow, busy
  );
endinterface

// File: rtl/chunked_signed_negate.sv
// Multi-cycle pass / negate / abs unit; the invert-plus-one carry ripples one CHUNK slice per cycle.
// Build option NEGATE_SATURATE_EN: saturate to max positive on overflow instead of wrapping.
module chunked_signed_negate #(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               reset,
  chunked_signed_negate_if.slave bus
);

  localparam int STEPS = BITS / CHUNK;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(STEPS - 1);
  localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};
`ifdef NEGATE_SATURATE_EN
  localparam logic [BITS-1:0] MAX_POS  = {1'b0, {(BITS-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [BITS-1:0] x_q;
  logic            neg_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic [BITS-1:0] out_data_q, out_data_d;
  logic            out_valid_q;
  logic            overflow_q, overflow_d;

  logic             last_slice;
  logic             neg_in;
  logic [CHUNK-1:0] x_slice, s_slice, sum_slice;
  logic [CHUNK:0]   chain;
  int               base;

  assign last_slice = (idx_q == LAST_IDX);
  assign neg_in     = (bus.mode == 2'b01) | ((bus.mode == 2'b10) & bus.in_data[BITS-1]);

  // One slice of ~x + 1 (or plain x when neg_q is clear, since the carry is then 0).
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    base       = CHUNK * int'(idx_q);
    x_slice    = x_q[base +: CHUNK];
    s_slice    = neg_q ? ~x_slice : x_slice;
    chain      = '0;
    chain[0]   = carry_q;
    sum_slice  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum_slice[i] = s_slice[i] ^ chain[i];
      chain[i+1]   = s_slice[i] & chain[i];
    end
    overflow_d = neg_q & (x_q == MOST_NEG);
    out_data_d = out_data_q;
    out_data_d[base +: CHUNK] = sum_slice;
`ifdef NEGATE_SATURATE_EN
    if (last_slice && overflow_d) out_data_d = MAX_POS;
`endif
  end

  // NOTE: synchronous reset covers datapath registers too, so out_data reads 0 after any abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      neg_q       <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.in_data;
            neg_q      <= neg_in;
            carry_q    <= neg_in;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          out_data_q <= out_data_d;
          carry_q    <= chain[CHUNK];
          if (last_slice) begin
            overflow_q  <= overflow_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_chunked_signed_negate.sv
// Directed bench for chunked_signed_negate: 32/8 unit plus 5/5 and 5/1 units swept exhaustively.
// Expected overflow data follows NEGATE_SATURATE_EN in the same way as the design.
module tb_chunked_signed_negate;

`ifdef NEGATE_SATURATE_EN
  localparam logic [31:0] OVF32 = 32'h7FFF_FFFF;
  localparam bit          SAT   = 1'b1;
`else
  localparam logic [31:0] OVF32 = 32'h8000_0000;
  localparam bit          SAT   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  chunked_signed_negate_if #(.BITS(32)) b32 ();
  chunked_signed_negate_if #(.BITS(5))  b5a ();
  chunked_signed_negate_if #(.BITS(5))  b5b ();

  chunked_signed_negate #(.BITS(32), .CHUNK(8)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  chunked_signed_negate #(.BITS(5),  .CHUNK(5)) dut5a (.clk(clk), .reset(reset), .bus(b5a.slave));
  chunked_signed_negate #(.BITS(5),  .CHUNK(1)) dut5b (.clk(clk), .reset(reset), .bus(b5b.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with the 32-bit unit idle; returns result and latency in cycles.
  task automatic op32(input logic [1:0] m, input logic [31:0] x,
                      output logic [31:0] res, output logic ovf, output int lat);
    b32.in_valid = 1'b1;
    b32.mode     = m;
    b32.in_data  = x;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b32.out_data;
    ovf = b32.overflow;
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
  endtask

  task automatic chk32(input string tag, input logic [1:0] m, input logic [31:0] x,
                       input logic [31:0] exp, input logic exp_ovf);
    logic [31:0] res;
    logic        ovf;
    int          lat;
    op32(m, x, res, ovf, lat);
    check({tag, "_data"}, res, exp);
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_lat"}, lat, 32'd4);
  endtask

  // Drives both 5-bit units with the same operand and records each one's latency.
  task automatic op5(input logic [1:0] m, input logic [4:0] x,
                     output logic [4:0] ra, output logic oa, output int la,
                     output logic [4:0] rb, output logic ob, output int lb);
    b5a.in_valid = 1'b1; b5a.mode = m; b5a.in_data = x;
    b5b.in_valid = 1'b1; b5b.mode = m; b5b.in_data = x;
    @(posedge clk); #1;
    b5a.in_valid = 1'b0;
    b5b.in_valid = 1'b0;
    la = -1; lb = -1; ra = '0; rb = '0; oa = 1'b0; ob = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (la < 0 && b5a.out_valid) begin la = cyc; ra = b5a.out_data; oa = b5a.overflow; end
      if (lb < 0 && b5b.out_valid) begin lb = cyc; rb = b5b.out_data; ob = b5b.overflow; end
      if (la >= 0 && lb >= 0) break;
    end
    b5a.out_ready = 1'b1;
    b5b.out_ready = 1'b1;
    @(posedge clk); #1;
    b5a.out_ready = 1'b0;
    b5b.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] res;
    logic        ovf;
    int          lat;

    b32.in_valid = 1'b0; b32.in_data = '0; b32.mode = '0; b32.out_ready = 1'b0;
    b5a.in_valid = 1'b0; b5a.in_data = '0; b5a.mode = '0; b5a.out_ready = 1'b0;
    b5b.in_valid = 1'b0; b5b.in_data = '0; b5b.mode = '0; b5b.out_ready = 1'b0;

    // Reset state, with in_valid high to show it is ignored under reset.
    b32.in_valid = 1'b1; b32.mode = 2'b01; b32.in_data = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
    reset = 1'b0;
    check("rst_in_ready", 32'(b32.in_ready), 32'd1);
    check("rst_out_valid", 32'(b32.out_valid), 32'd0);
    check("rst_out_data", b32.out_data, 32'd0);
    check("rst_overflow", 32'(b32.overflow), 32'd0);
    check("rst_busy", 32'(b32.busy), 32'd0);

    // Directed 32-bit vectors.
    chk32("neg5",      2'b01, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0);
    chk32("abs_m7",    2'b10, 32'hFFFF_FFF9, 32'h0000_0007, 1'b0);
    chk32("abs_7",     2'b10, 32'h0000_0007, 32'h0000_0007, 1'b0);
    chk32("neg0",      2'b01, 32'h0000_0000, 32'h0000_0000, 1'b0);
    chk32("neg_min",   2'b01, 32'h8000_0000, OVF32,         1'b1);
    chk32("abs_min",   2'b10, 32'h8000_0000, OVF32,         1'b1);
    chk32("pass",      2'b00, 32'h1234_5678, 32'h1234_5678, 1'b0);
    chk32("rsvd",      2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    chk32("pass_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk32("neg256",    2'b01, 32'h0000_0100, 32'hFFFF_FF00, 1'b0);
    chk32("neg_m1",    2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk32("neg_max",   2'b01, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0);
    chk32("abs_big",   2'b10, 32'hFFFF_0000, 32'h0001_0000, 1'b0);

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    b32.in_valid = 1'b1; b32.mode = 2'b01; b32.in_data = 32'h0001_0000;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    check("bp_busy_run", 32'(b32.busy), 32'd1);
    lat = 0;
    while (!b32.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", lat, 32'd4);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        b32.in_valid = 1'b1; b32.mode = 2'b01; b32.in_data = 32'h0000_0009;
      end
      if (c == 4) b32.in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_data", b32.out_data, 32'hFFFF_0000);
      check("bp_ovf", 32'(b32.overflow), 32'd0);
      check("bp_in_ready", 32'(b32.in_ready), 32'd0);
      check("bp_valid", 32'(b32.out_valid), 32'd1);
    end
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    check("bp_rel_valid", 32'(b32.out_valid), 32'd0);
    check("bp_rel_in_ready", 32'(b32.in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_not_queued", 32'(b32.busy), 32'd0);

    // Reset on the second RUN cycle aborts the operation.
    b32.in_valid = 1'b1; b32.mode = 2'b01; b32.in_data = 32'h0000_0005;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", 32'(b32.out_valid), 32'd0);
    check("abort_data", b32.out_data, 32'd0);
    check("abort_in_ready", 32'(b32.in_ready), 32'd1);
    check("abort_busy", 32'(b32.busy), 32'd0);
    op32(2'b01, 32'h0000_0005, res, ovf, lat);
    check("post_abort_data", res, 32'hFFFF_FFFB);
    check("post_abort_lat", lat, 32'd4);

    // Exhaustive 5-bit sweep: single-step (CHUNK=5) and bit-serial (CHUNK=1) units.
    for (int m = 0; m < 4; m++) begin
      for (int x = 0; x < 32; x++) begin
        logic [4:0] xv, exp, ra, rb;
        logic       neg, exp_ovf, oa, ob;
        int         la, lb;
        xv      = 5'(x);
        neg     = (m == 1) || (m == 2 && xv[4]);
        exp     = neg ? (5'd0 - xv) : xv;
        exp_ovf = neg && (xv == 5'h10);
        if (exp_ovf && SAT) exp = 5'h0F;
        op5(2'(m), xv, ra, oa, la, rb, ob, lb);
        check($sformatf("c5_m%0d_x%0d_data", m, x), 32'(ra), 32'(exp));
        check($sformatf("c5_m%0d_x%0d_ovf", m, x), 32'(oa), 32'(exp_ovf));
        check($sformatf("c5_m%0d_x%0d_lat", m, x), la, 32'd1);
        check($sformatf("c1_m%0d_x%0d_data", m, x), 32'(rb), 32'(exp));
        check($sformatf("c1_m%0d_x%0d_ovf", m, x), 32'(ob), 32'(exp_ovf));
        check($sformatf("c1_m%0d_x%0d_lat", m, x), lb, 32'd5);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
